s2qed_apu_arbiter: RTL

S2QED_APU_ARBITER -- requirements
Module: s2qed_apu_arbiter

---
 rtl/s2qed_apu_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/s2qed_apu_arbiter.sv
// Two-core APU arbiter: round-robin request selection with a hold-until-grant lock,
// plus an owner-tag FIFO that routes in-order responses back to the issuing core.
module s2qed_apu_arbiter #(
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_TYPE_W       = 1,
    parameter int APU_NDSFLAGS_CPU = 15,
    parameter int APU_NUSFLAGS_CPU = 5,
    parameter int DEPTH            = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,

    input  logic                                apu_req_1_i,
    output logic                                apu_gnt_1_o,
    input  logic [APU_NARGS_CPU-1:0][31:0]      apu_operands_1_i,
    input  logic [APU_WOP_CPU-1:0]              apu_op_1_i,
    input  logic [APU_TYPE_W-1:0]               apu_type_1_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]         apu_flags_1_i,
    input  logic                                apu_ready_1_i,
    output logic                                apu_valid_1_o,
    output logic [31:0]                         apu_result_1_o,
    output logic [APU_NUSFLAGS_CPU-1:0]         apu_rflags_1_o,

    input  logic                                apu_req_2_i,
    output logic                                apu_gnt_2_o,
    input  logic [APU_NARGS_CPU-1:0][31:0]      apu_operands_2_i,
    input  logic [APU_WOP_CPU-1:0]              apu_op_2_i,
    input  logic [APU_TYPE_W-1:0]               apu_type_2_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]         apu_flags_2_i,
    input  logic                                apu_ready_2_i,
    output logic                                apu_valid_2_o,
    output logic [31:0]                         apu_result_2_o,
    output logic [APU_NUSFLAGS_CPU-1:0]         apu_rflags_2_o,

    output logic                                apu_req_o,
    input  logic                                apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]      apu_operands_o,
    output logic [APU_WOP_CPU-1:0]              apu_op_o,
    output logic [APU_TYPE_W-1:0]               apu_type_o,
    output logic [APU_NDSFLAGS_CPU-1:0]         apu_flags_o,
    input  logic                                apu_valid_i,
    input  logic [31:0]                         apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]         apu_flags_i,
    output logic                                apu_ready_o,

    output logic [$clog2(DEPTH):0]              outstanding_o,
    output logic                                err_o
);

    localparam int CW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_CNT = (CW+1)'(DEPTH);

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // Core ids are encoded as one bit: 0 = core 1, 1 = core 2.
    arb_state_t           state;
    logic                 lock_id;
    logic                 rr;
    logic [DEPTH-1:0]     tag_fifo;
    logic [CW-1:0]        wr_ptr;
    logic [CW-1:0]        rd_ptr;
    logic [CW:0]          count;

    logic                 sel;
    logic                 sel_req;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 head;

    // A pending-but-ungranted request keeps ownership of the APU port until granted.
    always_comb begin
        sel = 1'b0;
        if (state == ARB_LOCKED) begin
            sel = lock_id;
        end else if (apu_req_1_i && apu_req_2_i) begin
            sel = ~rr;
        end else if (apu_req_2_i) begin
            sel = 1'b1;
        end
    end

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign sel_req = sel ? apu_req_2_i : apu_req_1_i;
    assign head    = tag_fifo[rd_ptr];

    // Reset gating is needed only here: everything else derives from cleared state.
    assign apu_req_o = sel_req & ~full & ~rst_i;
    assign push      = apu_req_o & apu_gnt_i;
    assign pop       = apu_valid_i & ~empty;

    assign apu_gnt_1_o = apu_gnt_i & apu_req_o & ~sel;
    assign apu_gnt_2_o = apu_gnt_i & apu_req_o & sel;

    always_comb begin
        apu_operands_o = '0;
        apu_op_o       = '0;
        apu_type_o     = '0;
        apu_flags_o    = '0;
        if (apu_req_o) begin
            if (sel) begin
                apu_operands_o = apu_operands_2_i;
                apu_op_o       = apu_op_2_i;
                apu_type_o     = apu_type_2_i;
                apu_flags_o    = apu_flags_2_i;
            end else begin
                apu_operands_o = apu_operands_1_i;
                apu_op_o       = apu_op_1_i;
                apu_type_o     = apu_type_1_i;
                apu_flags_o    = apu_flags_1_i;
            end
        end
    end

    // Responses go to the oldest outstanding owner; nothing is routed with no owner.
    always_comb begin
        apu_valid_1_o  = 1'b0;
        apu_valid_2_o  = 1'b0;
        apu_result_1_o = '0;
        apu_result_2_o = '0;
        apu_rflags_1_o = '0;
        apu_rflags_2_o = '0;
        if (!empty) begin
            if (head) begin
                apu_valid_2_o  = apu_valid_i;
                apu_result_2_o = apu_result_i;
                apu_rflags_2_o = apu_flags_i;
            end else begin
                apu_valid_1_o  = apu_valid_i;
                apu_result_1_o = apu_result_i;
                apu_rflags_1_o = apu_flags_i;
            end
        end
    end

    assign apu_ready_o   = empty | (head ? apu_ready_2_i : apu_ready_1_i);
    assign outstanding_o = count;

    // Lock FSM; a full FIFO freezes the lock since no transfer can complete.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ARB_IDLE;
            lock_id <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (apu_req_o && !apu_gnt_i) begin
                        state   <= ARB_LOCKED;
                        lock_id <= sel;
                    end
                end
                ARB_LOCKED: begin
                    if (apu_gnt_i && !full) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr       <= 1'b1;
            tag_fifo <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_o    <= 1'b0;
        end else begin
            if (push) begin
                tag_fifo[wr_ptr] <= sel;
                wr_ptr           <= wr_ptr + 1'b1;
                rr               <= sel;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (apu_valid_i && empty) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
